// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for signed two's-complement operands (truncation toward zero).
module seq_divider #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dzo_q, dzo_d;

  logic [WIDTH:0]     r_sh;
  logic [WIDTH+1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   r_new, q_new;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  assign dvd_mag = dividend_i[WIDTH-1] ? WIDTH'(-dividend_i) : dividend_i;
  assign dvs_mag = divisor_i[WIDTH-1]  ? WIDTH'(-divisor_i)  : divisor_i;
  assign quo_fix = neg_quo_q ? WIDTH'(-q_new) : q_new;
  assign rem_fix = neg_rem_q ? WIDTH'(-r_new) : r_new;

  always_comb begin
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (state_q == StIdle && start_i) begin
      neg_quo_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      neg_rem_d = dividend_i[WIDTH-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  assign dvd_mag = dividend_i;
  assign dvs_mag = divisor_i;
  assign quo_fix = q_new;
  assign rem_fix = r_new;
`endif

  // Shifted partial remainder can reach 2*divisor-1, so the trial subtract keeps a sign bit.
  assign r_sh  = {r_q, q_q[WIDTH-1]};
  assign diff  = {1'b0, r_sh} - {2'b00, dvs_q};
  assign ge    = ~diff[WIDTH+1];
  assign r_new = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
  assign q_new = {q_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          dvs_d   = dvs_mag;
          r_d     = '0;
          if (divisor_i == '0) begin
            // Divide-by-zero spends one RUN cycle and returns the raw dividend.
            dz_d  = 1'b1;
            q_d   = dividend_i;
            cnt_d = CNT_W'(1);
          end else begin
            dz_d  = 1'b0;
            q_d   = dvd_mag;
            cnt_d = CNT_W'(WIDTH);
          end
        end
      end
      StRun: begin
        if (dz_q) begin
          state_d = StDone;
          quo_d   = '1;
          rem_d   = q_q;
          dzo_d   = 1'b1;
        end else begin
          r_d   = r_new;
          q_d   = q_new;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StDone;
            quo_d   = quo_fix;
            rem_d   = rem_fix;
            dzo_d   = 1'b0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
    end
  end

  assign busy_o      = (state_q == StRun);
  assign done_o      = (state_q == StDone);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dzo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: issued operations push expected results and done cycle,
// a monitor pops and compares on every done pulse.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_zero;
  logic [7:0] quotient, remainder;

  seq_divider #(.WIDTH(8), .CNT_W(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .busy_o     (busy),
    .done_o     (done),
    .quotient_o (quotient),
    .remainder_o(remainder),
    .div_zero_o (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_pulses = 0;
  int   busy_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] dd, input logic [7:0] dv);
    exp_t e;
    int a, b;
    e.cyc = 0;
    if (dv == 8'd0) begin
      e.q = 8'hFF;
      e.r = dd;
      e.dz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      a = $signed(dd);
      b = $signed(dv);
`else
      a = int'(dd);
      b = int'(dv);
`endif
      e.q = 8'(a / b);
      e.r = 8'(a % b);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cycles++;
    if (done) begin
      done_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_zero", div_zero, e.dz);
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_exp(input logic [7:0] dd, input logic [7:0] dv);
    exp_t e;
    e = model(dd, dv);
    e.cyc = cyc + 1 + ((dv == 8'd0) ? 1 : 8);
    exp_q.push_back(e);
  endtask

  // Called at a negedge; drives start for exactly one edge.
  task automatic issue(input logic [7:0] dd, input logic [7:0] dv, input bit expect_it);
    wait_idle();
    dividend = dd;
    divisor = dv;
    start = 1'b1;
    if (expect_it) push_exp(dd, dv);
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom_range(255);
    divisor = $urandom_range(255);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_quotient"}, quotient, 8'd0);
    check({tag, "_remainder"}, remainder, 8'd0);
    check({tag, "_div_zero"}, div_zero, 1'b0);
  endtask

  initial begin
    int p0;
    logic [7:0] dd, dv;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of an operation discards it.
    issue(8'd100, 8'd7, 1'b0);
    @(negedge clk);
    check("midrun_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    p0 = done_pulses;
    repeat (12) @(negedge clk);
    check("midrun_no_done", done_pulses - p0, 0);

    busy_cycles = 0;
    issue(8'd100, 8'd7, 1'b1);
    drain();
    check("busy_cycles_100_7", busy_cycles, 8);
    repeat (5) @(negedge clk);
    check("hold_quotient", quotient, 8'd14);
    check("hold_remainder", remainder, 8'd2);
    check("hold_div_zero", div_zero, 1'b0);

    issue(8'd5, 8'd0, 1'b1);
    issue(8'd9, 8'd3, 1'b1);
    issue(8'd3, 8'd10, 1'b1);
    issue(8'd255, 8'd1, 1'b1);
    issue(8'd255, 8'd255, 1'b1);
    issue(8'd77, 8'd77, 1'b1);
    drain();

    // Start held high for a whole operation, dividend changed mid-run.
    wait_idle();
    dividend = 8'd200;
    divisor = 8'd9;
    start = 1'b1;
    push_exp(8'd200, 8'd9);
    p0 = done_pulses;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 3) dividend = 8'd50;
      if (done) break;
    end
    check("held_start_done_seen", done, 1'b1);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("held_start_one_pulse", done_pulses - p0, 1);
    check("held_start_quotient", quotient, 8'd22);

    for (int i = 0; i < 40; i++) begin
      dd = 8'($urandom);
      dv = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
      issue(dd, dv, 1'b1);
    end
    drain();

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(8'hF9, 8'd2, 1'b1);
    drain();
    check("signed_m7_2_q", quotient, 8'hFD);
    check("signed_m7_2_r", remainder, 8'hFF);
    issue(8'd7, 8'hFE, 1'b1);
    drain();
    check("signed_7_m2_q", quotient, 8'hFD);
    check("signed_7_m2_r", remainder, 8'h01);
    issue(8'h80, 8'hFF, 1'b1);
    drain();
    check("signed_m128_m1_q", quotient, 8'h80);
    check("signed_m128_m1_r", remainder, 8'h00);
`endif

    drain();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

endmodule
